// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs sized loads/stores over a req/ack data bus,
// stalls EX while an access is outstanding and hands the result to writeback.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        wb_valid,
    output logic [31:0] Read_Data,
    output logic [31:0] alu_out,
    output logic        sel,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic [1:0]  exc_out
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        wb_valid_q, wb_valid_d, sel_q, sel_d, regw_q, regw_d;
    logic [31:0] rdata_q, rdata_d, alu_q, alu_d;
    logic [4:0]  rd_q, rd_d, rd_pend_q, rd_pend_d;
    logic        rw_pend_q, rw_pend_d, ld_q, ld_d;
    logic [1:0]  exc_q, exc_d, off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_mem, bad, to_hit;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, shifted, ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_mem = mem_read | mem_write;
        bad = is_mem & ((funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                         (funct3[1:0] == 2'b01 && addr[0]) ||
                         (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
                         (mem_read & mem_write));

        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{store_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data;
            end
        endcase
        if (!mem_write) be_n = 4'b1111;

        // Lane selection uses the offset and size captured at request time.
        shifted = bus_rdata >> {off_q, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ext = {24'h0, ld_byte};
            3'b101:  ext = {16'h0, ld_half};
            default: ext = bus_rdata;
        endcase

        to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        alu_d       = alu_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        rd_pend_d   = rd_pend_q;
        rw_pend_d   = rw_pend_q;
        ld_d        = ld_q;
        off_d       = off_q;
        f3_d        = f3_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        regw_d      = 1'b0;
        exc_d       = 2'b00;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && !is_mem) begin
                    alu_d      = alu_in;
                    sel_d      = 1'b1;
                    rd_d       = rd_in;
                    regw_d     = reg_write_in;
                    wb_valid_d = 1'b1;
                end else if (in_valid && bad) begin
                    rd_d       = rd_in;
                    wb_valid_d = 1'b1;
                    exc_d      = 2'b01;
                end else if (in_valid) begin
                    stall       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_n;
                    bus_wdata_d = wdata_n;
                    cnt_d       = '0;
                    f3_d        = funct3;
                    off_d       = addr[1:0];
                    ld_d        = mem_read;
                    rd_pend_d   = rd_in;
                    rw_pend_d   = reg_write_in;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d  = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    rd_d       = rd_pend_q;
                    if (ld_q) begin
                        sel_d   = 1'b0;
                        rdata_d = ext;
                        regw_d  = rw_pend_q;
                    end else begin
                        rdata_d = '0;
                    end
                end else if (to_hit) begin
                    bus_req_d  = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    rd_d       = rd_pend_q;
                    exc_d      = 2'b10;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            wb_valid_q  <= 1'b0;
            rdata_q     <= '0;
            alu_q       <= '0;
            sel_q       <= 1'b1;
            rd_q        <= '0;
            regw_q      <= 1'b0;
            exc_q       <= 2'b00;
            rd_pend_q   <= '0;
            rw_pend_q   <= 1'b0;
            ld_q        <= 1'b0;
            off_q       <= '0;
            f3_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            wb_valid_q  <= wb_valid_d;
            rdata_q     <= rdata_d;
            alu_q       <= alu_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            regw_q      <= regw_d;
            exc_q       <= exc_d;
            rd_pend_q   <= rd_pend_d;
            rw_pend_q   <= rw_pend_d;
            ld_q        <= ld_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;
    assign wb_valid      = wb_valid_q;
    assign Read_Data     = rdata_q;
    assign alu_out       = alu_q;
    assign sel           = sel_q;
    assign rd_out        = rd_q;
    assign reg_write_out = regw_q;
    assign exc_out       = exc_q;

endmodule
